// File: rtl/iir_notch_mac_sequencer.sv
// Time-multiplexed biquad notch controller: one shared signed MAC runs b0,b1,b2,-a1,-a2 per sample.
// Latency: accept at edge k, result valid from edge k+6; back-pressure holds OUT and blocks new input.
module iir_notch_mac_sequencer #(
    parameter int WIDTH  = 16,
    parameter int COEF_W = 16,
    parameter int FRAC   = 14,
    parameter int ACC_W  = WIDTH + COEF_W + 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [WIDTH-1:0]  x_in_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [WIDTH-1:0]  y_out_o,
    output logic                     sat_o,
    input  logic                     cfg_we_i,
    input  logic [2:0]               cfg_addr_i,
    input  logic signed [COEF_W-1:0] cfg_wdata_i,
    output logic                     cfg_err_o,
    output logic                     busy_o
);
    localparam int PROD_W = WIDTH + COEF_W;

    localparam logic signed [COEF_W-1:0] UNITY =
        {{(COEF_W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [ACC_W-1:0] RND_HALF =
        {{(ACC_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAC0 = 3'd1,
        MAC1 = 3'd2,
        MAC2 = 3'd3,
        MAC3 = 3'd4,
        MAC4 = 3'd5,
        RND  = 3'd6,
        OUT  = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic signed [COEF_W-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic signed [COEF_W-1:0] b0_d, b1_d, b2_d, a1_d, a2_d;
    logic signed [WIDTH-1:0]  x_q, x1_q, x2_q, y1_q, y2_q;
    logic signed [WIDTH-1:0]  x_d, x1_d, x2_d, y1_d, y2_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [WIDTH-1:0]  y_q, y_d;
    logic                     sat_q, sat_d;
    logic                     cfg_err_q, cfg_err_d;

    logic                     accept;
    logic                     handshake;
    logic                     cfg_ok;

    logic signed [COEF_W-1:0] coef_sel;
    logic signed [WIDTH-1:0]  data_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  rnd_shift;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid_i) state_d = MAC0;
                MAC0:    state_d = MAC1;
                MAC1:    state_d = MAC2;
                MAC2:    state_d = MAC3;
                MAC3:    state_d = MAC4;
                MAC4:    state_d = RND;
                RND:     state_d = OUT;
                OUT:     if (out_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear in OUT must not let the aborted result complete a handshake.
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == OUT) && !clear_i;
        busy_o      = (state_q != IDLE);
    end

    assign accept    = in_valid_i && in_ready_o;
    assign handshake = out_valid_o && out_ready_i;

    // ---------------------------------------------------------------- MAC
    always_comb begin
        coef_sel = b0_q;
        data_sel = x_q;
        case (state_q)
            MAC1: begin coef_sel = b1_q; data_sel = x1_q; end
            MAC2: begin coef_sel = b2_q; data_sel = x2_q; end
            MAC3: begin coef_sel = a1_q; data_sel = y1_q; end
            MAC4: begin coef_sel = a2_q; data_sel = y2_q; end
            default: begin coef_sel = b0_q; data_sel = x_q; end
        endcase
    end

    assign prod     = coef_sel * data_sel;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        case (state_q)
            MAC0:       acc_d = prod_ext;
            MAC1, MAC2: acc_d = acc_q + prod_ext;
            MAC3, MAC4: acc_d = acc_q - prod_ext;
            default:    acc_d = acc_q;
        endcase
        if (clear_i) begin
            acc_d = '0;
        end
    end

    // Round half toward +inf, then clamp to the sample range.
    assign rnd_sum   = acc_q + RND_HALF;
    assign rnd_shift = rnd_sum >>> FRAC;

    always_comb begin
        y_d   = y_q;
        sat_d = sat_q;
        if (state_q == RND) begin
            if (rnd_shift > Y_MAX) begin
                y_d   = Y_MAX[WIDTH-1:0];
                sat_d = 1'b1;
            end else if (rnd_shift < Y_MIN) begin
                y_d   = Y_MIN[WIDTH-1:0];
                sat_d = 1'b1;
            end else begin
                y_d   = rnd_shift[WIDTH-1:0];
                sat_d = 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- history
    always_comb begin
        x_d  = x_q;
        x1_d = x1_q;
        x2_d = x2_q;
        y1_d = y1_q;
        y2_d = y2_q;
        if (accept) begin
            x_d = x_in_i;
        end
        if (handshake) begin
            x2_d = x1_q;
            x1_d = x_q;
            y2_d = y1_q;
            y1_d = y_q;
        end
        if (clear_i) begin
            x1_d = '0;
            x2_d = '0;
            y1_d = '0;
            y2_d = '0;
        end
    end

    // ---------------------------------------------------------------- config
    assign cfg_ok = cfg_we_i && (state_q == IDLE) && (cfg_addr_i <= 3'd4);

    always_comb begin
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        cfg_err_d = cfg_we_i && !cfg_ok;
        if (cfg_ok) begin
            case (cfg_addr_i)
                3'd0:    b0_d = cfg_wdata_i;
                3'd1:    b1_d = cfg_wdata_i;
                3'd2:    b2_d = cfg_wdata_i;
                3'd3:    a1_d = cfg_wdata_i;
                3'd4:    a2_d = cfg_wdata_i;
                default: b0_d = b0_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            b0_q      <= UNITY;
            b1_q      <= '0;
            b2_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            x_q       <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            sat_q     <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            x_q       <= x_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            sat_q     <= sat_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign y_out_o   = y_q;
    assign sat_o     = sat_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_iir_notch_mac_sequencer.sv
// Directed bench for iir_notch_mac_sequencer: expected outputs queued at send time, popped at output handshake.
module tb_iir_notch_mac_sequencer;
    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic               in_ready_o;
    logic signed [15:0] x_in;
    logic               out_valid_o;
    logic               out_ready;
    logic signed [15:0] y_out_o;
    logic               sat_o;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic signed [15:0] cfg_wdata;
    logic               cfg_err_o;
    logic               busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_edge = 0;
    int prev_edge = 0;
    bit ov_prev = 1'b0;
    logic [16:0] exp_q[$];
    int xv[5];
    int ev[5];

    iir_notch_mac_sequencer dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .x_in_i      (x_in),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .y_out_o     (y_out_o),
        .sat_o       (sat_o),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_err_o   (cfg_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [39:0] obs, input logic signed [39:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: latency on valid rise, scoreboard pop on handshake.
    always @(negedge clk) begin
        logic [16:0] e;
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid_o && !ov_prev) check("latency", cyc - acc_edge, 6);
            if (out_valid_o && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_out", y_out_o, $signed(e[15:0]));
                    check("sat", sat_o, e[16]);
                end
            end
            ov_prev = out_valid_o;
        end
    end

    task automatic send(input int x, input int ey, input bit es, input bit push, input bit chk_gap);
        int t = 0;
        logic [15:0] ey16;
        while (!in_ready_o && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("send_ready", in_ready_o, 1);
        x_in = x[15:0];
        in_valid = 1'b1;
        ey16 = ey[15:0];
        if (push) exp_q.push_back({es, ey16});
        @(posedge clk); #1;
        in_valid = 1'b0;
        prev_edge = acc_edge;
        acc_edge = cyc;
        if (chk_gap) check("accept_gap", acc_edge - prev_edge, 8);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !in_ready_o) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic cfg_write(input logic [2:0] a, input int d, input bit exp_err);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d[15:0];
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("cfg_err", cfg_err_o, exp_err);
        @(posedge clk); #1;
        check("cfg_err_pulse_end", cfg_err_o, 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready_o, 1);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_y_out"}, y_out_o, 0);
        check({tag, "_sat"}, sat_o, 0);
        check({tag, "_cfg_err"}, cfg_err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; x_in = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Passthrough with default coefficients, back to back
        send(50, 50, 0, 1, 0);
        send(-150, -150, 0, 1, 1);
        send(1000, 1000, 0, 1, 1);
        drain();

        // b0 = b2 = 1.0
        cfg_write(3'd2, 16384, 0);
        do_clear();
        xv = '{100, 200, 300, 0, 0};
        ev = '{100, 200, 400, 200, 300};
        for (int i = 0; i < 5; i++) send(xv[i], ev[i], 0, 1, i > 0);
        drain();

        // b0 = 1.0, a1 = -0.5: decaying response with rounding on the last term
        cfg_write(3'd2, 0, 0);
        cfg_write(3'd3, -8192, 0);
        do_clear();
        xv = '{1000, 0, 0, 0, 0};
        ev = '{1000, 500, 250, 125, 63};
        for (int i = 0; i < 5; i++) send(xv[i], ev[i], 0, 1, i > 0);
        drain();

        // b0 = b1 = 1.0: saturation in both directions
        cfg_write(3'd3, 0, 0);
        cfg_write(3'd1, 16384, 0);
        do_clear();
        send(30000, 30000, 0, 1, 0);
        send(30000, 32767, 1, 1, 1);
        drain();
        do_clear();
        send(-30000, -30000, 0, 1, 0);
        send(-30000, -32768, 1, 1, 1);
        drain();

        // Backpressure: stall in OUT, rejected config write during the stall
        cfg_write(3'd1, 0, 0);
        do_clear();
        out_ready = 1'b0;
        send(77, 77, 0, 1, 0);
        t = 0;
        while (!out_valid_o && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_valid", out_valid_o, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_y_stable", y_out_o, 77);
            check("bp_in_ready", in_ready_o, 0);
            check("bp_out_valid", out_valid_o, 1);
        end
        cfg_write(3'd1, 16384, 1);
        out_ready = 1'b1;
        drain();
        send(5, 5, 0, 1, 0);
        drain();
        cfg_write(3'd6, 123, 1);

        // Abort during MAC2 with b0 = b2 = 1.0
        cfg_write(3'd2, 16384, 0);
        do_clear();
        send(40, 40, 0, 1, 0);
        send(60, 60, 0, 1, 1);
        drain();
        send(90, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_mac2", busy_o, 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("abort_idle", in_ready_o, 1);
        check("abort_busy", busy_o, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check("abort_no_valid", out_valid_o, 0);
        send(50, 50, 0, 1, 0);
        drain();

        // Asynchronous reset in the middle of MAC3
        send(123, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", busy_o, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(7, 7, 0, 1, 0);
        send(9, 9, 0, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/iir_notch_mac_sequencer.md
Name: iir_notch_mac_sequencer

Overview:
- Time-multiplexed controller for the second-order IIR notch stage in the DEM-DAC noise-shaping path.
- Drives one shared signed multiply-accumulate through the five biquad terms per sample: y = (b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) scaled by 2^-FRAC.
- Owns the coefficient registers, the x[n-1], x[n-2], y[n-1], y[n-2] history, and the valid/ready handshakes to the upstream modulator and the downstream DEM encoder.

Parameters:
- WIDTH, 16, sample width (input, output and history, signed).
- COEF_W, 16, coefficient width, signed Q(COEF_W-FRAC).FRAC.
- FRAC, 14, coefficient fractional bits.
- ACC_W, WIDTH+COEF_W+4, accumulator width, signed.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous history clear; coefficients are kept.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  sequencer accepts a sample.
- x_in_i  in  WIDTH  input sample, signed.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- y_out_o  out  WIDTH  filtered sample, signed, saturated.
- sat_o  out  1  the current y_out_o was saturated.
- cfg_we_i  in  1  coefficient write strobe.
- cfg_addr_i  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5–7 reserved.
- cfg_wdata_i  in  COEF_W  coefficient value.
- cfg_err_o  out  1  one-cycle pulse on a rejected config write.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - in_ready_o=1, out_valid_o=0, y_out_o=0, sat_o=0, cfg_err_o=0, busy_o=0.
  - History registers and accumulator are 0.
  - Coefficients: b0=2^FRAC (1.0), b1=b2=a1=a2=0, giving passthrough.
- FSM states:
  - IDLE to MAC0 on in_valid_i & in_ready_o. The sample is latched.
  - MAC0..MAC4 advance unconditionally, one term per cycle, in order b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2.
  - MAC4 to RND. RND to OUT. OUT to IDLE on out_valid_o & out_ready_i.
- Handshakes:
  - in_ready_o = (state==IDLE).
  - out_valid_o = (state==OUT). y_out_o and sat_o are held stable while out_valid_o=1 and out_ready_i=0.
- Latency and throughput:
  - Accept at edge k. The accumulator is cleared and loaded with the first product at edge k+1. Terms complete at edges k+1..k+5.
  - RND registers y_out_o at edge k+6; out_valid_o is high from k+6.
  - With out_ready_i=1: handshake at k+7, next accept no earlier than edge k+8. Peak throughput is 1 sample per 8 clocks.
- Arithmetic:
  - Each product is full-precision signed; sign is extended to ACC_W.
  - In RND: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half toward +inf).
  - Saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1]. sat_o=1 if clamped.
  - The accumulator never wraps within ACC_W for legal coefficients.
- History update: only at the output handshake edge. x2←x1, x1←x, y2←y1, y1←saturated y.
- clear_i:
  - In IDLE: zeroes history next edge.
  - In any other state: aborts the current sample, zeroes history, returns to IDLE, forces out_valid_o=0. No output is produced for the aborted sample.
- Config writes:
  - Accepted only in IDLE with cfg_addr_i≤4; take effect next edge.
  - In a non-IDLE state, or with a reserved address: write is ignored and cfg_err_o pulses for exactly one cycle.
  - A config write coinciding with an input accept in IDLE is applied; the new coefficient is used for that sample.
- Mid-operation reset: asynchronous reset in any state immediately applies all reset values. The in-flight sample is lost.

Test Plan:
- Reset defaults, passthrough: inputs 50, −150, 1000.
  - Outputs 50, −150, 1000, each with out_valid_o rising 6 clocks after accept.
  - Throughput 8 clocks/sample with out_ready_i=1.
- Config b0=b2=16384, b1=a1=a2=0: inputs 100, 200, 300, 0, 0 → outputs 100, 200, 400, 200, 300.
- Config b0=16384, a1=−8192, others 0: inputs 1000, 0, 0, 0, 0 → outputs 1000, 500, 250, 125, 63 (rounding check).
- Config b0=b1=16384: inputs 30000, 30000.
  - Outputs 30000 (sat_o=0), then 32767 (sat_o=1).
  - Repeat with −30000 → −32768, sat_o=1.
- Backpressure: hold out_ready_i=0 for 10 cycles in OUT.
  - y_out_o stays stable, in_ready_o=0.
  - cfg write to b1 during the stall → cfg_err_o one-cycle pulse and b1 unchanged.
  - Write to cfg_addr_i=6 in IDLE → cfg_err_o pulse.
- Abort: assert clear_i during MAC2.
  - FSM returns to IDLE, no out_valid_o, history=0.
  - Next input 50 with b0=b2=16384 → output 50.
  - Assert reset_i mid-MAC3 → all outputs at reset values asynchronously.
